minterm_sweeper: RTL and testbench

Parametrised, programmable N-input Boolean function unit. The function is held as a 2^N-bit truth-table mask, loaded serially, and interpreted as either a sum of minterms or a product of maxterms. On command the block sweeps every input combination in order and streams one (index, f) beat per combination over a valid/ready handshake. When the sweep ends it reports how many combinations evaluated to 1. It replaces the fixed per-function SoP/PoS modules in the lab sequence and acts as a self-checking truth-table generator for them.

---
 rtl/minterm_sweeper_pkg.sv | 18 +
 rtl/minterm_sweeper_mask.sv | 37 +++
 rtl/minterm_sweeper.sv | 152 +++++++++++++++
 tb/tb_minterm_sweeper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/minterm_sweeper_pkg.sv
// Shared types and constants for the minterm sweeper: FSM state encoding,
// function-mode encoding and the truth-table width helper.
package minterm_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    function automatic int unsigned mask_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/minterm_sweeper_mask.sv
// Serial-in, parallel-out truth-table mask register. New bits enter at bit 0,
// so the first bit shifted in ends up at the highest index after W shifts.
module mask_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         shift_in,
    output logic [W-1:0] mask
);

    logic [W-1:0] mask_q;
    logic [W-1:0] mask_d;

    // Next mask value: shift left by one when enabled, otherwise hold.
    always_comb begin
        mask_d = mask_q;
        if (shift_en) begin
            mask_d = {mask_q[W-2:0], shift_in};
        end else begin
            mask_d = mask_q;
        end
    end

    // Mask storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= {W{1'b0}};
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/minterm_sweeper.sv
// Programmable N-input Boolean function unit: sweeps every input combination
// of a serially loaded truth-table mask and streams (index, f) beats.
module minterm_sweeper
    import minterm_sweeper_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  logic         load_bit,
    input  logic         mode,
    input  logic         start,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_index,
    output logic         out_f,
    output logic         done,
    output logic [N:0]   ones_count,
    output logic         busy
);

    localparam int W = int'(mask_width(N));

    state_e       state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_index_q, out_index_d;
    logic         out_f_q, out_f_d;
    logic         done_q, done_d;
    logic [N:0]   ones_count_q, ones_count_d;
    logic         busy_q, busy_d;

    logic [W-1:0] mask_s;
    logic         shift_en_s;
    logic [N-1:0] idx_inc_s;
    logic [N:0]   cnt_inc_s;

    // Loading only in IDLE, and a simultaneous start wins over the load.
    assign shift_en_s = (state_q == ST_IDLE) && load_en && !start;
    assign idx_inc_s  = idx_q + {{(N-1){1'b0}}, 1'b1};
    assign cnt_inc_s  = cnt_q + {{N{1'b0}}, out_f_q};

    mask_shift_reg #(
        .W(W)
    ) u_mask (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .shift_in (load_bit),
        .mask     (mask_s)
    );

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_f_d      = out_f_q;
        done_d       = 1'b0;
        ones_count_d = ones_count_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SWEEP;
                    mode_d      = mode;
                    idx_d       = {N{1'b0}};
                    cnt_d       = {(N+1){1'b0}};
                    out_valid_d = 1'b1;
                    out_index_d = {N{1'b0}};
                    out_f_d     = mask_s[0] ^ mode;
                    busy_d      = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (out_valid_q && out_ready) begin
                    cnt_d = cnt_inc_s;
                    // Last combination: stop here rather than wrapping the index.
                    if (idx_q == {N{1'b1}}) begin
                        state_d      = ST_DONE;
                        out_valid_d  = 1'b0;
                        out_index_d  = {N{1'b0}};
                        out_f_d      = 1'b0;
                        done_d       = 1'b1;
                        ones_count_d = cnt_inc_s;
                    end else begin
                        idx_d       = idx_inc_s;
                        out_index_d = idx_inc_s;
                        out_f_d     = mask_s[idx_inc_s] ^ mode_q;
                    end
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= {N{1'b0}};
            cnt_q        <= {(N+1){1'b0}};
            mode_q       <= MODE_SOP;
            out_valid_q  <= 1'b0;
            out_index_q  <= {N{1'b0}};
            out_f_q      <= 1'b0;
            done_q       <= 1'b0;
            ones_count_q <= {(N+1){1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_f_q      <= out_f_d;
            done_q       <= done_d;
            ones_count_q <= ones_count_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_index  = out_index_q;
    assign out_f      = out_f_q;
    assign done       = done_q;
    assign ones_count = ones_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench for minterm_sweeper: an N=3 and an N=4 instance share the
// control inputs; each test targets one instance and checks its beat stream.
module tb_minterm_sweeper;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic       load_bit;
    logic       mode;
    logic       start;
    logic       out_ready;

    logic       v3, f3, d3, b3;
    logic [2:0] i3;
    logic [3:0] oc3;
    logic       v4, f4, d4, b4;
    logic [3:0] i4;
    logic [4:0] oc4;

    int tests_run;
    int tests_failed;
    int exp_q[$];
    logic [15:0] m3_model;
    logic [15:0] m4_model;

    minterm_sweeper #(.N(3)) u_dut3 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_bit(load_bit),
        .mode(mode), .start(start), .out_valid(v3), .out_ready(out_ready),
        .out_index(i3), .out_f(f3), .done(d3), .ones_count(oc3), .busy(b3)
    );

    minterm_sweeper #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_bit(load_bit),
        .mode(mode), .start(start), .out_valid(v4), .out_ready(out_ready),
        .out_index(i4), .out_f(f4), .done(d4), .ones_count(oc4), .busy(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input int n, output int v, output int idx, output int f,
                          output int d, output int oc, output int b);
        if (n == 3) begin
            v = int'(v3); idx = int'(i3); f = int'(f3);
            d = int'(d3); oc = int'(oc3); b = int'(b3);
        end else begin
            v = int'(v4); idx = int'(i4); f = int'(f4);
            d = int'(d4); oc = int'(oc4); b = int'(b4);
        end
    endtask

    task automatic do_load(input int n, input logic [15:0] m);
        for (int k = (1 << n) - 1; k >= 0; k--) begin
            @(negedge clk);
            load_en  = 1'b1;
            load_bit = m[k];
        end
        @(negedge clk);
        load_en  = 1'b0;
        load_bit = 1'b0;
    endtask

    task automatic run_sweep(input int n, input logic md, input int stall_idx,
                             input int stall_len, input bit inject,
                             input int exp_ones, input string nm);
        int v, idx, f, d, oc, b;
        int beats, stalls, sv_idx, sv_f, e;
        bit got_done, prev_stall;
        logic [15:0] mm;
        mm = (n == 3) ? m3_model : m4_model;
        beats = 0; stalls = 0; sv_idx = 0; sv_f = 0;
        got_done = 1'b0; prev_stall = 1'b0;
        @(negedge clk);
        mode = md; start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < (1 << n); i++) begin
            exp_q.push_back((i << 1) | int'(mm[i] ^ md));
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            sample(n, v, idx, f, d, oc, b);
            if (inject) begin
                start = 1'b1; load_en = 1'b1; load_bit = 1'b1; mode = ~md;
            end else begin
                start = 1'b0;
            end
            if (cyc == 1) begin
                check_eq({nm, " first_idx"}, idx, 0);
            end
            if (d != 0) begin
                got_done = 1'b1;
                start = 1'b0; load_en = 1'b0; load_bit = 1'b0; out_ready = 1'b1;
                check_eq({nm, " done_cycle"}, cyc, (1 << n) + 1 + stall_len);
                check_eq({nm, " ones_count"}, oc, exp_ones);
                break;
            end
            check_eq({nm, " valid"}, v, 1);
            check_eq({nm, " busy"}, b, 1);
            if (prev_stall) begin
                check_eq({nm, " stall_idx_hold"}, idx, sv_idx);
                check_eq({nm, " stall_f_hold"}, f, sv_f);
            end
            if (idx == stall_idx && stalls < stall_len) begin
                out_ready  = 1'b0;
                stalls++;
                prev_stall = 1'b1;
                sv_idx     = idx;
                sv_f       = f;
            end else begin
                out_ready  = 1'b1;
                prev_stall = 1'b0;
                if (exp_q.size() == 0) begin
                    check_eq({nm, " extra_beat"}, idx, -1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq({nm, " idx"}, idx, e >> 1);
                    check_eq({nm, " f"}, f, e & 1);
                    beats++;
                end
            end
        end
        if (!got_done) begin
            check_eq({nm, " timeout"}, 0, 1);
        end
        check_eq({nm, " beats"}, beats, 1 << n);
        check_eq({nm, " leftover"}, exp_q.size(), 0);
        exp_q.delete();
        mode = 1'b0;
        @(negedge clk);
        sample(n, v, idx, f, d, oc, b);
        check_eq({nm, " done_pulse_end"}, d, 0);
        check_eq({nm, " idle_busy"}, b, 0);
        check_eq({nm, " ones_hold"}, oc, exp_ones);
    endtask

    initial begin
        int v, idx, f, d, oc, b;
        int dcount;
        bit found;
        tests_run = 0; tests_failed = 0;
        reset = 1'b1; load_en = 1'b0; load_bit = 1'b0;
        mode = 1'b0; start = 1'b0; out_ready = 1'b1;
        m3_model = 16'h0000; m4_model = 16'h0000;
        repeat (3) @(negedge clk);
        sample(3, v, idx, f, d, oc, b);
        check_eq("rst3 valid", v, 0);
        check_eq("rst3 index", idx, 0);
        check_eq("rst3 f", f, 0);
        check_eq("rst3 done", d, 0);
        check_eq("rst3 ones", oc, 0);
        check_eq("rst3 busy", b, 0);
        reset = 1'b0;

        do_load(3, 16'h00E4);
        m3_model = 16'h00E4;
        run_sweep(3, 1'b0, -1, 0, 1'b0, 4, "sop3");
        run_sweep(3, 1'b1, -1, 0, 1'b0, 4, "pos3");

        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m4_model = 16'h0000;
        do_load(4, 16'h90D6);
        m4_model = 16'h90D6;
        run_sweep(4, 1'b0, -1, 0, 1'b0, 7, "sop4");
        run_sweep(4, 1'b0, 5, 3, 1'b0, 7, "bp4");
        run_sweep(4, 1'b0, -1, 0, 1'b1, 7, "ign4");
        run_sweep(4, 1'b0, -1, 0, 1'b0, 7, "post_ign4");

        // Abort a sweep with reset while index 3 is on the output.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            sample(4, v, idx, f, d, oc, b);
            if (v != 0 && idx == 3) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_mid reach_idx3", int'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        sample(4, v, idx, f, d, oc, b);
        check_eq("rst_mid valid", v, 0);
        check_eq("rst_mid ones", oc, 0);
        check_eq("rst_mid done", d, 0);
        check_eq("rst_mid busy", b, 0);
        reset = 1'b0;
        m4_model = 16'h0000;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            sample(4, v, idx, f, d, oc, b);
            dcount += d;
        end
        check_eq("rst_mid no_done", dcount, 0);
        run_sweep(4, 1'b0, -1, 0, 1'b0, 0, "zero4");

        do_load(4, 16'hFFFF);
        m4_model = 16'hFFFF;
        run_sweep(4, 1'b0, -1, 0, 1'b0, 16, "ones4");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
